// File: rtl/fpu_mul_pkg.sv
// Shared constants for the FPU MUL mantissa path.
//   MANT_W     : mantissa width of both operands
//   SLICE_W    : OperandB bits consumed per sequencer step
//   NUM_SLICES : steps per product (MANT_W / SLICE_W)
//   PP_W       : width of one partial product (MANT_W x SLICE_W)
//   PROD_W     : full product width
//   IDLE/RUN/HOLD : sequencer state encodings
package fpu_mul_pkg;
  localparam int MANT_W     = 24;
  localparam int SLICE_W    = 8;
  localparam int NUM_SLICES = MANT_W / SLICE_W;
  localparam int PP_W       = MANT_W + SLICE_W;
  localparam int PROD_W     = 2 * MANT_W;
  localparam int CNT_W      = $clog2(NUM_SLICES);

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t HOLD = 2'd2;
endpackage

// File: rtl/mul_sequencer_if.sv
// Handshake and partial-multiplier bus of the mantissa multiply sequencer.
//   in_valid/in_ready     : operand-side handshake, operand_a/operand_b payload
//   pp_operand_a/_b       : operands presented to the external 24x8 multiplier
//   pp_result             : combinational partial product returned by it
//   out_valid/out_ready   : result-side handshake, mul_result payload
// slave is the sequencer's view, master the surrounding datapath's view.
interface mul_sequencer_if;
  import fpu_mul_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [MANT_W-1:0]   operand_a;
  logic [MANT_W-1:0]   operand_b;
  logic [MANT_W-1:0]   pp_operand_a;
  logic [SLICE_W-1:0]  pp_operand_b;
  logic [PP_W-1:0]     pp_result;
  logic                out_valid;
  logic                out_ready;
  logic [PROD_W-1:0]   mul_result;

  modport slave (
    input  in_valid, operand_a, operand_b, pp_result, out_ready,
    output in_ready, pp_operand_a, pp_operand_b, out_valid, mul_result
  );

  modport master (
    output in_valid, operand_a, operand_b, pp_result, out_ready,
    input  in_ready, pp_operand_a, pp_operand_b, out_valid, mul_result
  );
endinterface

// File: rtl/adder.sv
// Plain unsigned W-bit adder; carry out is not produced.
//   a, b : addends
//   sum  : a + b modulo 2^W
module Adder #(
  parameter int W = 48
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/mul_seq_acc.sv
// Shift-and-add accumulator for the sliced mantissa multiply.
//   clk, rst  : clock, synchronous active-high reset
//   pp_result : partial product of the current OperandB slice
//   cnt       : slice index, selects the shift (SLICE_W * cnt)
//   first     : discard the old accumulator contents this step
//   en        : register the new sum
//   acc_nxt   : value the accumulator takes at the next enabled edge
module mul_seq_acc
  import fpu_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PP_W-1:0]   pp_result,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              first,
  input  logic              en,
  output logic [PROD_W-1:0] acc_nxt
);
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] base;
  logic [PROD_W-1:0] addend;

  // first step overwrites instead of adding, so no separate clear cycle
  assign base   = first ? '0 : acc;
  assign addend = {{(PROD_W-PP_W){1'b0}}, pp_result} << (SLICE_W * cnt);

  Adder #(.W(PROD_W)) u_add (
    .a   (base),
    .b   (addend),
    .sum (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (en)
      acc <= acc_nxt;
  end
endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle 24x24 mantissa multiply controller. One external 24x8
// multiplier is time-shared over three cycles, one OperandB byte per cycle.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : operand handshake, partial-multiplier port, result handshake
//
// state | meaning
// IDLE  | no operation, ready for operands
// RUN   | stepping through OperandB slices, cnt = current slice
// HOLD  | product presented on mul_result with out_valid high
module mul_sequencer
  import fpu_mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mul_sequencer_if.slave  bus
);
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [MANT_W-1:0]  a_q;
  logic [MANT_W-1:0]  b_q;
  logic               out_valid_q;
  logic [PROD_W-1:0]  result_q;
  logic [PROD_W-1:0]  acc_nxt;
  logic               accept;
  logic               last;

  assign bus.in_ready     = (state == IDLE) | ((state == HOLD) & bus.out_ready);
  assign accept           = bus.in_valid & bus.in_ready;
  assign last             = (cnt == CNT_W'(NUM_SLICES - 1));
  assign bus.pp_operand_a = a_q;
  assign bus.pp_operand_b = (state == RUN) ? SLICE_W'(b_q >> (SLICE_W * cnt)) : '0;
  assign bus.out_valid    = out_valid_q;
  assign bus.mul_result   = result_q;

  mul_seq_acc u_acc (
    .clk       (clk),
    .rst       (rst),
    .pp_result (bus.pp_result),
    .cnt       (cnt),
    .first     (cnt == '0),
    .en        (state == RUN),
    .acc_nxt   (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= bus.operand_a;
            b_q   <= bus.operand_b;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (last) begin
            // capture the final sum directly so the result survives the
            // accumulator being overwritten by the next operation
            result_q    <= acc_nxt;
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              a_q   <= bus.operand_a;
              b_q   <= bus.operand_b;
              cnt   <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller for the 24x24 mantissa multiply in the FPU MUL path.
- Time-shares one external combinational 24x8 partial-product multiplier over three cycles, one byte slice of OperandB per cycle.
- Accumulates slices at bit offsets 0, 8 and 16 into the 48-bit product.
- Valid/ready handshake on both sides; sits between MUL operand unpack and MUL normalisation.

Parameters:
- MANT_W, 24, mantissa width of both operands.
- SLICE_W, 8, OperandB slice width per step; NUM_SLICES = MANT_W/SLICE_W (derived localparam, 3).

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- InValid  input  1  operand pair valid.
- InReady  output  1  sequencer accepts operands.
- OperandA  input  MANT_W  multiplicand mantissa.
- OperandB  input  MANT_W  multiplier mantissa.
- PPOperandA  output  MANT_W  to partial multiplier, latched OperandA.
- PPOperandB  output  SLICE_W  to partial multiplier, current OperandB slice.
- PPResult  input  MANT_W+SLICE_W  partial product, combinational same cycle.
- OutValid  output  1  MULResult valid.
- OutReady  input  1  consumer accepts result.
- MULResult  output  2*MANT_W  unsigned product.

Behaviour:
- Clk is the only clock. Rst is synchronous and active-high.
- States: IDLE, RUN, HOLD. Slice counter Cnt is 0..NUM_SLICES-1.
- Reset values: state IDLE, Cnt 0, accumulator 0, latched A/B 0, OutValid 0, MULResult 0. InReady is 1 once the state is IDLE.
- InReady = (state==IDLE) | (state==HOLD & OutReady). Combinational; never depends on InValid.
- Accept (InValid & InReady at an edge):
  - latch OperandA and OperandB;
  - Cnt <= 0;
  - state <= RUN.
- RUN, each cycle:
  - PPOperandA = latched A; PPOperandB = latched B[SLICE_W*Cnt +: SLICE_W].
  - At the edge, acc <= (Cnt==0 ? 0 : acc) + (PPResult << SLICE_W*Cnt), zero-extended to 48 bits. The first step overwrites, so no separate clear is needed.
  - If Cnt==NUM_SLICES-1: state <= HOLD, OutValid <= 1. Otherwise Cnt <= Cnt+1.
- Latency: accept at edge k, accumulate at edges k+1..k+3, OutValid high after edge k+3.
- HOLD:
  - MULResult = acc, held stable while OutValid & !OutReady.
  - On OutValid & OutReady: OutValid <= 0 and state <= IDLE.
  - If InValid is also high in the same cycle, accept the new operands instead and go straight to RUN (state RUN, OutValid 0).
  - Peak throughput is one product per 4 cycles.
- In IDLE and HOLD, PPOperandB is driven 0. PPOperandA holds the latched value.
- MULResult is a registered copy of acc and keeps its last value after the handshake. Consumers qualify it with OutValid.
- Arithmetic: unsigned throughout. Sum is bounded by (2^24-1)^2 < 2^48, so the 48-bit accumulator cannot overflow and no carry is dropped.
- InValid while in RUN is ignored: InReady is 0 and operands are not sampled.
- Rst asserted in any state, including mid-RUN or in HOLD with OutValid high:
  - the in-flight operation is discarded;
  - all state returns to reset values at that edge;
  - no OutValid pulse is produced.
- OperandA or OperandB equal to 0 still takes the full 3 cycles; there is no early termination.

Decomposition:
- Shared package fpu_mul_pkg holds:
  - MANT_W, SLICE_W and NUM_SLICES constants;
  - state encodings IDLE=2'd0, RUN=2'd1, HOLD=2'd2;
  - product width 2*MANT_W.
- One natural sub-module, mul_seq_acc: the 48-bit shift-and-add accumulator (inputs PPResult, Cnt, First, En; output acc). It reuses the existing Adder#(48).
- The FSM and handshake stay in mul_sequencer. The 24x8 partial multiplier stays external.

Test Plan:
- A=0xFFFFFF, B=0xFFFFFF, OutReady=1 -> OutValid exactly 3 cycles after accept, MULResult=0xFFFFFE000001.
- A=0x800000, B=0x800000 -> MULResult=0x400000000000. A=0x123456, B=0x000001 -> MULResult=0x000000123456, with PPOperandB sequence 0x01, 0x00, 0x00.
- Product A=0x000003, B=0x020100 completes (expected 0x000000060300). Then hold OutReady=0 for 5 cycles -> OutValid stays 1, MULResult stable at 0x000000060300, InReady=0, and a new InValid is not accepted.
- In HOLD, OutReady=1 and InValid=1 with A=0x000002, B=0x000005 in the same cycle -> old result consumed, new operands accepted that edge, next result 0x00000000000A exactly 3 cycles later.
- Rst pulsed during RUN at Cnt=1 -> next cycle state IDLE, InReady=1, OutValid=0, MULResult=0. A subsequent A=0x000007, B=0x000006 yields 0x00000000002A.
- Random 1000 operand pairs with random OutReady/InValid stalls -> every MULResult equals A*B, no result lost or duplicated, and operands are never sampled while InReady=0.
